sudoku_mask_decode: RTL

Sequential decoder for the 729-bit candidate mask produced by the mask elimination stages. It captures a mask on `start` and walks the 81 cells one per handshake, emitting each cell's resolved digit and candidate count on a valid/ready stream. On completion it reports whole-puzzle status (solved count, contradiction). It sits after the elimination pipeline and feeds the puzzle writeback and checker logic.

---
 rtl/sudoku_mask_decode.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sudoku_mask_decode.sv
// Walks a latched 729-bit candidate mask one cell per valid/ready beat and reports
// per-cell digit/count plus puzzle totals. Define SUDOKU_DECODE_PUZZLE_OUT_EN for puzzle_out.
module sudoku_mask_decode (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [728:0] puzzle_mask_bin,
    output logic         busy,
    output logic         cell_valid,
    input  logic         cell_ready,
    output logic [6:0]   cell_idx,
    output logic [3:0]   cell_value,
    output logic [3:0]   cell_count,
    output logic         done,
    output logic [6:0]   solved_cnt,
    output logic         error
`ifdef SUDOKU_DECODE_PUZZLE_OUT_EN
    ,
    output logic [323:0] puzzle_out
`endif
);

    localparam int NCELL = 81;
    localparam int NDIG  = 9;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [6:0]                 cell_idx_q, cell_idx_d;
    logic [6:0]                 solved_q, solved_d;
    logic                       error_q, error_d;
    logic [NCELL-1:0][NDIG-1:0] mask_q;

    logic            in_scan, xfer, load;
    logic [NDIG-1:0] cell_bits;
    logic [3:0]      zero_cnt, zero_val;

    assign in_scan = (state_q == S_SCAN);
    assign xfer    = in_scan && cell_ready;
    assign load    = (state_q == S_IDLE) && start;

    // NOTE: the mask is pure data and is never observed outside SCAN, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            mask_q <= puzzle_mask_bin;
        end
    end

    // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
    always_comb begin
        cell_bits = mask_q[cell_idx_q];
        zero_cnt  = '0;
        zero_val  = '0;
        for (int v = 0; v < NDIG; v++) begin
            if (!cell_bits[v]) begin
                zero_cnt = zero_cnt + 4'd1;
                zero_val = 4'(v + 1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cell_idx_d = cell_idx_q;
        solved_d   = solved_q;
        error_d    = error_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SCAN;
                    cell_idx_d = '0;
                    solved_d   = '0;
                    error_d    = 1'b0;
                end
            end
            S_SCAN: begin
                if (cell_ready) begin
                    if (zero_cnt == 4'd1) solved_d = solved_q + 7'd1;
                    if (zero_cnt == 4'd0) error_d  = 1'b1;
                    if (cell_idx_q == 7'(NCELL - 1)) state_d = S_DONE;
                    else                             cell_idx_d = cell_idx_q + 7'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cell_idx_q <= '0;
            solved_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cell_idx_q <= cell_idx_d;
            solved_q   <= solved_d;
            error_q    <= error_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign cell_valid = in_scan;
    assign done       = (state_q == S_DONE);
    assign cell_idx   = cell_idx_q;
    assign cell_count = in_scan ? zero_cnt : 4'd0;
    assign cell_value = (in_scan && zero_cnt == 4'd1) ? zero_val : 4'd0;
    assign solved_cnt = solved_q;
    assign error      = error_q;

`ifdef SUDOKU_DECODE_PUZZLE_OUT_EN
    logic [NCELL-1:0][3:0] puzzle_q, puzzle_d;

    always_comb begin
        puzzle_d = puzzle_q;
        if (load) begin
            puzzle_d = '0;
        end else if (xfer) begin
            puzzle_d[cell_idx_q] = cell_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) puzzle_q <= '0;
        else     puzzle_q <= puzzle_d;
    end

    assign puzzle_out = puzzle_q;
`endif

endmodule
